// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - generic valid/ready pipeline stage with 2-entry skid buffer
// Registered in_ready_o; flush/start/stall gating; saturating stall and drop counters.
module pipe_stage_skid #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n_i,
  input  logic              start_i,
  output logic              start_o,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  drop_cnt_o
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] main_q, skid_q;
  logic              in_ready_q, start_q;
  logic [CNT_W-1:0]  stall_cnt_q, drop_cnt_q;
  logic              eff_ready, push, pop;
  logic              load_main_in, load_main_skid, load_skid;
  logic [1:0]        held;
  logic [CNT_W:0]    drop_sum;

  assign eff_ready   = out_ready_i & ~stall_i;
  assign out_valid_o = (state != EMPTY);
  assign push        = in_valid_i & in_ready_q & start_i;
  assign pop         = out_valid_o & eff_ready & start_i;
  assign held        = (state == TWO) ? 2'd2 : ((state == ONE) ? 2'd1 : 2'd0);
  assign drop_sum    = {1'b0, drop_cnt_q} + (CNT_W+1)'(held);

  always_ff @(posedge clk) begin
    if (!rst_n_i) state <= EMPTY;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush_i) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (push) state_nxt = ONE;
        ONE: begin
          if (push && !pop)      state_nxt = TWO;
          else if (pop && !push) state_nxt = EMPTY;
        end
        TWO:     if (pop) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (!flush_i) begin
      case (state)
        EMPTY: load_main_in = push;
        ONE: begin
          load_main_in = push & pop;
          load_skid    = push & ~pop;
        end
        TWO:     load_main_skid = pop;
        default: ;
      endcase
    end
  end

  // Ready is computed from the next state so it never depends on out_ready_i combinationally.
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      main_q     <= FLUSH_VAL;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      start_q    <= start_i;
      in_ready_q <= start_i & (state_nxt != TWO);
      if (flush_i)             main_q <= FLUSH_VAL;
      else if (load_main_in)   main_q <= in_data_i;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid) skid_q <= in_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (start_i && out_valid_o && !eff_ready && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_i)
        drop_cnt_q <= drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    end
  end

  assign in_ready_o  = in_ready_q;
  assign start_o     = start_q;
  assign out_data_o  = main_q;
  assign stall_cnt_o = stall_cnt_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule
